// File: rtl/rsa_arb_pkg.sv
// Shared types and defaults for the RSA core start arbiter.
package rsa_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } arb_state_e;

  localparam int TIMEOUT_DEFAULT = 1024;

endpackage

// File: rtl/rsa_start_arbiter_rr_pick.sv
// Combinational round-robin picker: first pending index after last_grant, wrapping modulo N_REQ.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int SEL_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] pending,
  input  logic [SEL_W-1:0] last_grant,
  output logic             valid,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] cand_s;

  // Scan from the farthest offset inwards so the nearest pending index is the one left in idx.
  always_comb begin
    valid  = 1'b0;
    idx    = {SEL_W{1'b0}};
    cand_s = {SEL_W{1'b0}};
    for (int k = N_REQ; k >= 1; k--) begin
      cand_s = SEL_W'((int'(last_grant) + k) % N_REQ);
      valid  = valid | pending[cand_s];
      idx    = pending[cand_s] ? cand_s : idx;
    end
  end

endmodule

// File: rtl/rsa_start_arbiter.sv
// Round-robin start scheduler sharing one RSA core among N_REQ requesters.
// Optional watchdog abort of a stuck core is built when RSA_ARB_TIMEOUT_EN is defined.
module rsa_start_arbiter
  import rsa_arb_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int SEL_W   = $clog2(N_REQ),
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic             core_start,
  output logic [SEL_W-1:0] core_sel,
  input  logic             core_done,
  output logic [N_REQ-1:0] ack,
  output logic             busy,
  output logic             timeout
);

  localparam logic [N_REQ-1:0] LSB_ONE = {{(N_REQ-1){1'b0}}, 1'b1};

  arb_state_e       state_r;
  logic [N_REQ-1:0] req_q_r;
  logic [N_REQ-1:0] pending_r;
  logic [N_REQ-1:0] edge_s;
  logic [N_REQ-1:0] clr_s;
  logic [N_REQ-1:0] ack_r;
  logic [SEL_W-1:0] sel_r;
  logic [SEL_W-1:0] last_grant_r;
  logic [SEL_W-1:0] pick_idx_s;
  logic             pick_valid_s;
  logic             core_start_r;
  logic             busy_r;

`ifdef RSA_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT);
  logic [CNT_W-1:0] wd_cnt_r;
  logic             timeout_r;
`endif

  rr_pick #(
    .N_REQ(N_REQ),
    .SEL_W(SEL_W)
  ) u_rr_pick (
    .pending   (pending_r),
    .last_grant(last_grant_r),
    .valid     (pick_valid_s),
    .idx       (pick_idx_s)
  );

  // Rising-edge detect and the clear mask for the index being launched.
  always_comb begin
    edge_s = req & ~req_q_r;
    clr_s  = (state_r == ISSUE) ? (LSB_ONE << sel_r) : {N_REQ{1'b0}};
  end

  // Request sampling; a new edge on the issuing index outranks its clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q_r   <= {N_REQ{1'b1}};
      pending_r <= {N_REQ{1'b0}};
    end else begin
      req_q_r   <= req;
      pending_r <= (pending_r & ~clr_s) | edge_s;
    end
  end

  // Job sequencing with all outputs registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      sel_r        <= {SEL_W{1'b0}};
      last_grant_r <= SEL_W'(N_REQ - 1);
      core_start_r <= 1'b0;
      ack_r        <= {N_REQ{1'b0}};
      busy_r       <= 1'b0;
`ifdef RSA_ARB_TIMEOUT_EN
      wd_cnt_r     <= {CNT_W{1'b0}};
      timeout_r    <= 1'b0;
`endif
    end else begin
      core_start_r <= 1'b0;
      ack_r        <= {N_REQ{1'b0}};
`ifdef RSA_ARB_TIMEOUT_EN
      timeout_r    <= 1'b0;
`endif
      case (state_r)
        IDLE: begin
          if (pick_valid_s) begin
            sel_r        <= pick_idx_s;
            state_r      <= ISSUE;
            core_start_r <= 1'b1;
            busy_r       <= 1'b1;
          end
        end
        ISSUE: begin
          state_r <= WAIT;
`ifdef RSA_ARB_TIMEOUT_EN
          wd_cnt_r <= {CNT_W{1'b0}};
`endif
        end
        WAIT: begin
          if (core_done) begin
            state_r <= ACK;
            ack_r   <= LSB_ONE << sel_r;
`ifdef RSA_ARB_TIMEOUT_EN
          end else if (wd_cnt_r == CNT_W'(TIMEOUT - 1)) begin
            state_r   <= ACK;
            ack_r     <= LSB_ONE << sel_r;
            timeout_r <= 1'b1;
          end else begin
            wd_cnt_r <= wd_cnt_r + CNT_W'(1);
`endif
          end
        end
        ACK: begin
          state_r      <= IDLE;
          busy_r       <= 1'b0;
          last_grant_r <= sel_r;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign core_start = core_start_r;
  assign core_sel   = sel_r;
  assign ack        = ack_r;
  assign busy       = busy_r;

`ifdef RSA_ARB_TIMEOUT_EN
  assign timeout = timeout_r;
`else
  logic unused_cfg_s;
  assign unused_cfg_s = ^TIMEOUT;
  assign timeout      = 1'b0;
`endif

endmodule

// File: tb/tb_rsa_start_arbiter.sv
// Self-checking bench for rsa_start_arbiter: scenario tasks with randomized jobs against a job-level model.
module tb_rsa_start_arbiter;

  localparam int N  = 4;
  localparam int SW = 2;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  req = '0;
  logic          core_done = 1'b0;
  logic          core_start;
  logic [SW-1:0] core_sel;
  logic [N-1:0]  ack;
  logic          busy;
  logic          timeout;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int done_dly = 0;
  int done_at  = -1;
  int stray_at = -1;
  int to_cnt   = 0;
  int mdl_last = N - 1;
  int st_sel[$];
  int st_cyc[$];
  int ak_val[$];
  int ak_cyc[$];
  int ak_to[$];

  always #5 clk = ~clk;

  rsa_start_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .core_start(core_start), .core_sel(core_sel),
    .core_done(core_done), .ack(ack), .busy(busy), .timeout(timeout)
  );

  // One clock: log outputs seen after the edge and act as the core (done d cycles after start).
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (core_start === 1'b1) begin
      st_sel.push_back(int'(core_sel));
      st_cyc.push_back(cyc);
      if (done_dly > 0) done_at = cyc + done_dly;
    end
    if (ack !== '0) begin
      ak_val.push_back(int'(ack));
      ak_cyc.push_back(cyc);
      ak_to.push_back(int'(timeout));
    end
    if (timeout === 1'b1) to_cnt++;
    core_done = (cyc == done_at) || (cyc == stray_at);
  endtask

  task automatic clear_log();
    st_sel.delete(); st_cyc.delete(); ak_val.delete(); ak_cyc.delete(); ak_to.delete();
    to_cnt = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1; done_at = -1; stray_at = -1; done_dly = 0; core_done = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    mdl_last = N - 1;
    clear_log();
  endtask

  // Reference round robin: first set bit after 'last', wrapping.
  function automatic int ref_pick(input int pend, input int last);
    for (int k = 1; k <= N; k++) begin
      int p;
      p = (last + k) % N;
      if (((pend >> p) & 1) != 0) return p;
    end
    return -1;
  endfunction

  task automatic test_reset();
    req = '0;
    do_reset();
    n_tests++; if (core_start !== 1'b0) begin n_fail++; $display("FAIL reset_core_start got %b want 0", core_start); end
    n_tests++; if (ack !== 4'b0000) begin n_fail++; $display("FAIL reset_ack got %b want 0000", ack); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_tests++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout got %b want 0", timeout); end
    n_tests++; if (core_sel !== 2'd0) begin n_fail++; $display("FAIL reset_core_sel got %0d want 0", core_sel); end
  endtask

  task automatic test_single();
    int idx, d, r, es, ea;
    for (int it = 0; it < 5; it++) begin
      idx = (it == 0) ? 2 : int'($urandom_range(0, N - 1));
      d   = (it == 0) ? 5 : int'($urandom_range(1, 8));
      clear_log();
      stray_at = cyc + 1;
      tick(); tick();
      done_dly = d;
      req[idx] = 1'b1;
      r = cyc;
      repeat (d + 8) tick();
      req[idx] = 1'b0;
      tick(); tick();
      es = r + 2;
      ea = es + d + 1;
      n_tests++;
      if (st_sel.size() != 1 || ak_val.size() != 1) begin
        n_fail++;
        $display("FAIL single_count idx=%0d got starts=%0d acks=%0d want 1/1", idx, st_sel.size(), ak_val.size());
      end else begin
        n_tests++;
        if (st_sel[0] != idx || st_cyc[0] != es) begin
          n_fail++;
          $display("FAIL single_start got sel=%0d cyc=%0d want sel=%0d cyc=%0d", st_sel[0], st_cyc[0], idx, es);
        end
        n_tests++;
        if (ak_val[0] != (1 << idx) || ak_cyc[0] != ea || ak_to[0] != 0) begin
          n_fail++;
          $display("FAIL single_ack got ack=%0h cyc=%0d to=%0d want ack=%0h cyc=%0d to=0", ak_val[0], ak_cyc[0], ak_to[0], 1 << idx, ea);
        end
      end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy got %b want 0", busy); end
      mdl_last = idx;
    end
  endtask

  task automatic test_simultaneous();
    int masks[4];
    int order[$];
    int pend, last, d, r, es, ea;
    do_reset();
    masks[0] = 11;
    for (int m = 1; m < 4; m++) masks[m] = int'($urandom_range(1, 15));
    for (int m = 0; m < 4; m++) begin
      d = int'($urandom_range(1, 6));
      done_dly = d;
      clear_log();
      order.delete();
      pend = masks[m];
      last = mdl_last;
      while (pend != 0) begin
        last = ref_pick(pend, last);
        order.push_back(last);
        pend = pend & ~(1 << last);
      end
      req = masks[m][N-1:0];
      r = cyc;
      repeat (order.size() * (d + 4) + 6) tick();
      req = '0;
      tick(); tick();
      n_tests++;
      if (st_sel.size() != order.size() || ak_val.size() != order.size()) begin
        n_fail++;
        $display("FAIL sim_count mask=%0h got starts=%0d acks=%0d want %0d", masks[m], st_sel.size(), ak_val.size(), order.size());
      end else begin
        es = r + 2;
        foreach (order[j]) begin
          ea = es + d + 1;
          n_tests++;
          if (st_sel[j] != order[j] || st_cyc[j] != es || ak_val[j] != (1 << order[j]) || ak_cyc[j] != ea) begin
            n_fail++;
            $display("FAIL sim_job mask=%0h job=%0d got sel=%0d scyc=%0d ack=%0h acyc=%0d want sel=%0d scyc=%0d ack=%0h acyc=%0d",
                     masks[m], j, st_sel[j], st_cyc[j], ak_val[j], ak_cyc[j], order[j], es, 1 << order[j], ea);
          end
          es = ea + 2;
        end
      end
      mdl_last = last;
    end
  endtask

  task automatic test_held();
    clear_log();
    done_dly = 3;
    req[1] = 1'b1;
    repeat (20) tick();
    req[1] = 1'b0;
    repeat (4) tick();
    n_tests++;
    if (st_sel.size() != 1 || ak_val.size() != 1) begin
      n_fail++;
      $display("FAIL held_jobs got starts=%0d acks=%0d want 1/1", st_sel.size(), ak_val.size());
    end
    // Two edges on req[1] while it waits behind a long job for req[0].
    clear_log();
    done_dly = 20;
    req[0] = 1'b1;
    repeat (3) tick();
    req[1] = 1'b1; tick();
    req[1] = 1'b0; tick();
    req[1] = 1'b1; tick();
    req[1] = 1'b0; tick();
    repeat (56) tick();
    req[0] = 1'b0;
    tick();
    n_tests++;
    if (st_sel.size() != 2 || ak_val.size() != 2) begin
      n_fail++;
      $display("FAIL merge_count got starts=%0d acks=%0d want 2/2", st_sel.size(), ak_val.size());
    end else begin
      n_tests++;
      if (st_sel[0] != 0 || st_sel[1] != 1) begin
        n_fail++;
        $display("FAIL merge_order got %0d,%0d want 0,1", st_sel[0], st_sel[1]);
      end
    end
    mdl_last = 1;
  endtask

  task automatic test_owner_rereq();
    int exp_q[$];
    int pend, last;
    clear_log();
    done_dly = 10;
    exp_q.push_back(ref_pick(1, mdl_last));
    req[0] = 1'b1;
    repeat (4) tick();
    req[0] = 1'b0; tick();
    req[0] = 1'b1; req[2] = 1'b1; tick();
    pend = 5;
    last = exp_q[0];
    while (pend != 0) begin
      last = ref_pick(pend, last);
      exp_q.push_back(last);
      pend = pend & ~(1 << last);
    end
    repeat (60) tick();
    req = '0;
    tick();
    n_tests++;
    if (st_sel.size() != 3 || ak_val.size() != 3) begin
      n_fail++;
      $display("FAIL rereq_count got starts=%0d acks=%0d want 3/3", st_sel.size(), ak_val.size());
    end else begin
      n_tests++;
      if (st_sel[0] != exp_q[0] || st_sel[1] != exp_q[1] || st_sel[2] != exp_q[2]) begin
        n_fail++;
        $display("FAIL rereq_order got %0d,%0d,%0d want %0d,%0d,%0d", st_sel[0], st_sel[1], st_sel[2], exp_q[0], exp_q[1], exp_q[2]);
      end
    end
    mdl_last = last;
  endtask

  task automatic test_reset_mid();
    int n_before;
    clear_log();
    done_dly = 0;
    req[3] = 1'b1;
    repeat (5) tick();
    req[1] = 1'b1;
    repeat (2) tick();
    rst = 1'b1;
    stray_at = cyc + 1;
    tick();
    rst = 1'b0;
    n_before = st_sel.size();
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got %b want 0", busy); end
    repeat (20) tick();
    n_tests++;
    if (n_before != 1 || st_sel.size() != n_before) begin
      n_fail++;
      $display("FAIL rstmid_starts got before=%0d after=%0d want 1/1", n_before, st_sel.size());
    end
    n_tests++; if (ak_val.size() != 0) begin n_fail++; $display("FAIL rstmid_ack got %0d acks want 0", ak_val.size()); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_idle got busy=%b want 0", busy); end
    req = '0;
    tick();
    mdl_last = N - 1;
  endtask

  task automatic test_timeout();
    int r;
    clear_log();
    done_dly = 0;
    req[2] = 1'b1;
    r = cyc;
`ifdef RSA_ARB_TIMEOUT_EN
    repeat (20) tick();
    req[2] = 1'b0;
    tick(); tick();
    n_tests++;
    if (ak_val.size() != 1 || to_cnt != 1) begin
      n_fail++;
      $display("FAIL to_count got acks=%0d to_cycles=%0d want 1/1", ak_val.size(), to_cnt);
    end else begin
      n_tests++;
      if (ak_val[0] != 4 || ak_cyc[0] != r + 2 + 1 + TO || ak_to[0] != 1) begin
        n_fail++;
        $display("FAIL to_ack got ack=%0h cyc=%0d to=%0d want ack=4 cyc=%0d to=1", ak_val[0], ak_cyc[0], ak_to[0], r + 3 + TO);
      end
    end
    // Done arriving in the expiry cycle wins over the watchdog.
    clear_log();
    done_dly = TO;
    req[2] = 1'b1;
    r = cyc;
    repeat (20) tick();
    req[2] = 1'b0;
    tick();
    n_tests++;
    if (ak_val.size() != 1 || to_cnt != 0) begin
      n_fail++;
      $display("FAIL to_race_count got acks=%0d to_cycles=%0d want 1/0", ak_val.size(), to_cnt);
    end else begin
      n_tests++;
      if (ak_cyc[0] != r + 3 + TO || ak_to[0] != 0) begin
        n_fail++;
        $display("FAIL to_race_ack got cyc=%0d to=%0d want cyc=%0d to=0", ak_cyc[0], ak_to[0], r + 3 + TO);
      end
    end
`else
    repeat (50) tick();
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL nowd_busy got %b want 1", busy); end
    n_tests++;
    if (ak_val.size() != 0 || to_cnt != 0) begin
      n_fail++;
      $display("FAIL nowd_ack got acks=%0d to_cycles=%0d want 0/0", ak_val.size(), to_cnt);
    end
    req[2] = 1'b0;
    do_reset();
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_held();
    test_owner_rereq();
    test_reset_mid();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
